tx_header_enc: RTL and testbench
================================

TX_HEADER_ENC -- requirements
Module: tx_header_enc

Interface
REQ-001 SHALL have port clk_6M  input  1  6 MHz system clock; all state on its rising edge.
REQ-002 SHALL have port rstz  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port bit_p  input  1  one-cycle strobe marking each 1 us air-bit boundary.
REQ-004 SHALL have port start_p  input  1  one-cycle request to encode and send one header.
REQ-005 SHALL have port regi_LT_ADDR  input  3  logical transport address.
REQ-006 SHALL have port regi_packet_type  input  4  TYPE field.
REQ-007 SHALL have ports flow, arqn, seqn  input  1 each  header flag bits.
REQ-008 SHALL have port regi_my_BD_ADDR_UAP  input  8  HEC initial value.
REQ-009 SHALL have port clk_wh  input  6  CLK[6:1] whitening seed.
REQ-010 SHALL have port txbit  output  1  serial encoded header bit.
REQ-011 SHALL have port txhdr_busy  output  1  high from acceptance until last bit ends.
REQ-012 SHALL have port txhdr_done_p  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, SEND, DONE; IDLE->SEND on start_p, SEND->DONE after 54th bit_p, DONE->IDLE next cycle.
REQ-014 SHALL, on start_p in IDLE, latch all field inputs and uap/clk_wh; later input changes have no effect on that header.
REQ-015 SHALL ignore start_p while in SEND or DONE.
REQ-016 SHALL form 10-bit info word h[9:0] = {seqn, arqn, flow, type[3:0], lt_addr[2:0]}, transmitted h[0] first.
REQ-017 SHALL compute HEC with 8-bit LFSR seeded with UAP: per info bit b, fb=b^hec[7]; hec={hec[6:0],1'b0} ^ (fb ? 8'hA7 : 8'h00).
REQ-018 SHALL append HEC after h[9], sent hec[7] first, giving 18 header bits.
REQ-019 SHALL repeat each (whitened) header bit three times (rate-1/3 FEC), 54 air bits total.
REQ-020 SHALL drive txbit with air bit 0 from the cycle after start_p acceptance, advancing one air bit per bit_p in SEND.
REQ-021 SHALL hold txbit stable between bit_p strobes.
REQ-022 SHALL count repetition 0..2 and header index 0..17; index advances when repetition wraps 2->0.
REQ-023 SHALL, when start_p and bit_p coincide in IDLE, accept start and not count that bit_p.
REQ-024 SHALL assert txhdr_busy from the cycle after acceptance through the DONE cycle inclusive.
REQ-025 SHALL pulse txhdr_done_p for exactly the DONE cycle, and drive txbit=0 outside SEND.
REQ-026 SHALL permit a new start_p in the cycle following DONE (back-to-back headers).

Reset
REQ-027 SHALL, on rstz low, asynchronously force IDLE, counters 0, LFSRs 0, txbit=0, txhdr_busy=0, txhdr_done_p=0.
REQ-028 SHALL, on reset mid-SEND, abandon the header with no txhdr_done_p after release.

Configuration
REQ-029 SHALL, with TXHDR_WHITEN_EN defined, XOR each header bit before FEC with 7-bit LFSR D^7+D^4+1 seeded {1'b1, clk_wh}, stepping once per header bit.
REQ-030 SHALL, without TXHDR_WHITEN_EN, send header bits unwhitened and omit the whitening LFSR.

Verification
REQ-031 SHALL cover: whiten off, lt=3'b001, type=4'h2, flow=0, arqn=1, seqn=0, uap=8'h47 -> 54 bits match reference model, each bit tripled, done_p after 54th bit_p.
REQ-032 SHALL cover: start_p with bit_p same cycle -> first air bit held a full bit period, still 54 bits.
REQ-033 SHALL cover: second start_p at air bit 20 -> ignored, output unchanged, one done_p.
REQ-034 SHALL cover: rstz low at air bit 30 -> txbit=0, busy=0 immediately, no done_p after release.
REQ-035 SHALL cover: whiten on, clk_wh=6'h00 -> whitened bits equal model with seed 7'h40.
REQ-036 SHALL cover: two back-to-back headers -> second start the cycle after done_p, 108 bits, two done_p pulses.

Source files
------------

// File: rtl/tx_header_enc_if.sv
// Header-encoder bus: field inputs, bit strobe, start request and serial outputs.
interface tx_header_enc_if;
    logic       bit_p;
    logic       start_p;
    logic [2:0] regi_LT_ADDR;
    logic [3:0] regi_packet_type;
    logic       flow;
    logic       arqn;
    logic       seqn;
    logic [7:0] regi_my_BD_ADDR_UAP;
    logic [5:0] clk_wh;
    logic       txbit;
    logic       txhdr_busy;
    logic       txhdr_done_p;

    // Requester side: drives fields/strobes, observes the serial stream.
    modport master (
        output bit_p, start_p, regi_LT_ADDR, regi_packet_type,
               flow, arqn, seqn, regi_my_BD_ADDR_UAP, clk_wh,
        input  txbit, txhdr_busy, txhdr_done_p
    );

    // Encoder side.
    modport slave (
        input  bit_p, start_p, regi_LT_ADDR, regi_packet_type,
               flow, arqn, seqn, regi_my_BD_ADDR_UAP, clk_wh,
        output txbit, txhdr_busy, txhdr_done_p
    );
endinterface

// File: rtl/tx_header_enc.sv
// Packet header encoder: 10 info bits + 8-bit HEC, optional whitening,
// rate-1/3 repetition FEC, serialised one air bit per bit_p strobe.
// Optional feature macro: TXHDR_WHITEN_EN (7-bit D^7+D^4+1 whitening).
module tx_header_enc (
    input  logic           clk_6M,
    input  logic           rstz,
    tx_header_enc_if.slave hif
);

    localparam int unsigned INFO_W = 10;
    localparam int unsigned HEC_W  = 8;
    localparam int unsigned HDR_W  = INFO_W + HEC_W;
    localparam int unsigned REP_W  = 2;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WHT_W  = 7;

    localparam logic [REP_W-1:0] REP_LAST = REP_W'(2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HDR_W - 1);
    localparam logic [HEC_W-1:0] HEC_POLY = 8'hA7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HDR_W-1:0]   sreg_q, sreg_d;
    logic               txbit_q, txbit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wbit_d;
    logic [INFO_W-1:0]  info_c;
    logic [HEC_W-1:0]   hec_c;
    logic [HEC_W-1:0]   hec_rev_c;

`ifdef TXHDR_WHITEN_EN
    logic [WHT_W-1:0]   wl_q, wl_d;
`else
    logic               unused_clk_wh;
    assign unused_clk_wh = ^hif.clk_wh;
`endif

    // Serial HEC over the info word, LSB first, seeded with the UAP.
    function automatic logic [HEC_W-1:0] hec_calc(input logic [INFO_W-1:0] info,
                                                  input logic [HEC_W-1:0]  uap);
        logic [HEC_W-1:0] h;
        logic             fb;
        h = uap;
        for (int i = 0; i < int'(INFO_W); i++) begin
            fb = info[i] ^ h[HEC_W-1];
            h  = {h[HEC_W-2:0], 1'b0} ^ (fb ? HEC_POLY : '0);
        end
        return h;
    endfunction

    // Header word assembly: info bits first, then HEC MSB first.
    always_comb begin
        info_c    = {hif.seqn, hif.arqn, hif.flow, hif.regi_packet_type, hif.regi_LT_ADDR};
        hec_c     = hec_calc(info_c, hif.regi_my_BD_ADDR_UAP);
        hec_rev_c = '0;
        for (int k = 0; k < int'(HEC_W); k++) begin
            hec_rev_c[k] = hec_c[HEC_W-1-k];
        end
    end

    // Next-state, counters, shift register and registered-output values.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        sreg_d  = sreg_q;
`ifdef TXHDR_WHITEN_EN
        wl_d    = wl_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hif.start_p) begin
                    state_d = SEND;
                    rep_d   = '0;
                    idx_d   = '0;
                    sreg_d  = {hec_rev_c, info_c};
`ifdef TXHDR_WHITEN_EN
                    wl_d    = {1'b1, hif.clk_wh};
`endif
                end
            end
            SEND: begin
                if (hif.bit_p) begin
                    if (rep_q == REP_LAST) begin
                        rep_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                        end else begin
                            idx_d  = idx_q + IDX_W'(1);
                            sreg_d = {1'b0, sreg_q[HDR_W-1:1]};
`ifdef TXHDR_WHITEN_EN
                            wl_d   = {wl_q[WHT_W-2:0], wl_q[WHT_W-1]}
                                   ^ {2'b00, wl_q[WHT_W-1], 4'b0000};
`endif
                        end
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef TXHDR_WHITEN_EN
        wbit_d  = wl_d[WHT_W-1];
`else
        wbit_d  = 1'b0;
`endif
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        txbit_d = (state_d == SEND) ? (sreg_d[0] ^ wbit_d) : 1'b0;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            rep_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            txbit_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TXHDR_WHITEN_EN
            wl_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            txbit_q <= txbit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef TXHDR_WHITEN_EN
            wl_q    <= wl_d;
`endif
        end
    end

    assign hif.txbit        = txbit_q;
    assign hif.txhdr_busy   = busy_q;
    assign hif.txhdr_done_p = done_q;

endmodule

// File: tb/tb_tx_header_enc.sv
// Scoreboard bench for tx_header_enc: stimulus pushes expected air bits,
// a monitor pops and compares as each new air bit appears on txbit.
`timescale 1ns/1ps
module tb_tx_header_enc;

    localparam int AIR_BITS = 54;
    localparam int BIT_DIV  = 6;
    localparam int WAIT_MAX = 2000;

    logic clk_6M = 1'b0;
    logic rstz;

    tx_header_enc_if hif();

    tx_header_enc dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .hif    (hif)
    );

    always #83 clk_6M = ~clk_6M;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit exp_q[$];
    int exp_done  = 0;
    int got_done  = 0;
    int bits_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 18 header bits from the field rules, optional whitening, tripled.
    task automatic model_push(input logic [2:0] lt, input logic [3:0] ty,
                              input logic fl, input logic ar, input logic sq,
                              input logic [7:0] uap, input logic [5:0] cw);
        bit         h[18];
        logic [9:0] info;
        logic [7:0] hec;
        bit         fb;
        bit         wb;
`ifdef TXHDR_WHITEN_EN
        logic [6:0] w;
        w = {1'b1, cw};
`endif
        info = {sq, ar, fl, ty, lt};
        hec  = uap;
        for (int i = 0; i < 10; i++) begin
            h[i] = info[i];
            fb   = info[i] ^ hec[7];
            hec  = (hec << 1) ^ (fb ? 8'hA7 : 8'h00);
        end
        for (int k = 0; k < 8; k++) h[10+k] = hec[7-k];
        for (int j = 0; j < 18; j++) begin
            wb = 1'b0;
`ifdef TXHDR_WHITEN_EN
            wb = w[6];
            fb = w[6];
            w  = w << 1;
            if (fb) w = w ^ 7'h11;
`endif
            repeat (3) exp_q.push_back(h[j] ^ wb);
        end
        exp_done++;
        if (cw == 6'h3f) wb = 1'b0;
    endtask

    // Free-running 1 us air-bit strobe.
    initial begin
        int ph;
        ph = 0;
        hif.bit_p = 1'b0;
        forever begin
            @(posedge clk_6M);
            #1;
            hif.bit_p = (ph == BIT_DIV - 1);
            ph = (ph + 1) % BIT_DIV;
        end
    end

    task automatic scramble_fields();
        hif.regi_LT_ADDR        = 3'($urandom);
        hif.regi_packet_type    = 4'($urandom);
        hif.flow                = 1'($urandom);
        hif.arqn                = 1'($urandom);
        hif.seqn                = 1'($urandom);
        hif.regi_my_BD_ADDR_UAP = 8'($urandom);
        hif.clk_wh              = 6'($urandom);
    endtask

    // mode 0: start away from bit_p, 1: coincide with bit_p, 2: next cycle.
    task automatic start_hdr(input logic [2:0] lt, input logic [3:0] ty,
                             input logic fl, input logic ar, input logic sq,
                             input logic [7:0] uap, input logic [5:0] cw,
                             input int mode, input bit expect_accept);
        int guard;
        guard = 0;
        @(posedge clk_6M); #2;
        while (((mode == 0) && hif.bit_p) || ((mode == 1) && !hif.bit_p)) begin
            @(posedge clk_6M); #2;
            guard++;
            if (guard > 20) break;
        end
        hif.regi_LT_ADDR        = lt;
        hif.regi_packet_type    = ty;
        hif.flow                = fl;
        hif.arqn                = ar;
        hif.seqn                = sq;
        hif.regi_my_BD_ADDR_UAP = uap;
        hif.clk_wh              = cw;
        hif.start_p             = 1'b1;
        if (expect_accept) model_push(lt, ty, fl, ar, sq, uap, cw);
        @(posedge clk_6M); #2;
        hif.start_p = 1'b0;
        scramble_fields();
    endtask

    task automatic start_rand(input int mode);
        start_hdr(3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 8'($urandom), 6'($urandom), mode, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hif.txhdr_busy) && n < WAIT_MAX) begin
            @(posedge clk_6M); #2;
            n++;
        end
        check("drain_in_time", int'(n < WAIT_MAX), 1);
    endtask

    task automatic wait_bits(input int target);
        int n;
        n = 0;
        while (bits_seen != target && n < WAIT_MAX) begin
            @(posedge clk_6M); #2;
            n++;
        end
        check("reach_air_bit", bits_seen, target);
    endtask

    // Monitor: compare each new air bit, bit hold at strobe, and done timing.
    initial begin
        bit prev_busy, prev_bitp, cur;
        int nbits, nstrobe;
        prev_busy = 1'b0; prev_bitp = 1'b0; cur = 1'b0; nbits = 0; nstrobe = 0;
        forever begin
            @(negedge clk_6M);
            if (rstz !== 1'b1) begin
                prev_busy = 1'b0; prev_bitp = 1'b0; nbits = 0; nstrobe = 0;
                bits_seen = 0;
                continue;
            end
            if (hif.txhdr_busy && !hif.txhdr_done_p) begin
                if (!prev_busy || prev_bitp) begin
                    if (!prev_busy) begin
                        nbits = 0;
                        nstrobe = 0;
                    end
                    if (exp_q.size() == 0) begin
                        check("unexpected_air_bit", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check($sformatf("air_bit_%0d", nbits), int'(hif.txbit), int'(cur));
                    end
                    nbits++;
                    bits_seen = nbits;
                end else if (hif.bit_p) begin
                    check("air_bit_hold", int'(hif.txbit), int'(cur));
                end
                if (hif.bit_p) nstrobe++;
            end
            if (hif.txhdr_done_p) begin
                got_done++;
                check("done_after_strobes", nstrobe, AIR_BITS);
                check("bits_per_header", nbits, AIR_BITS);
                check("txbit_zero_in_done", int'(hif.txbit), 0);
                check("busy_in_done", int'(hif.txhdr_busy), 1);
            end
            prev_busy = hif.txhdr_busy;
            prev_bitp = hif.bit_p;
        end
    end

    initial begin
        #9_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        rstz = 1'b0;
        hif.start_p = 1'b0;
        scramble_fields();
        repeat (3) @(posedge clk_6M);
        @(negedge clk_6M);
        check("reset_txbit", int'(hif.txbit), 0);
        check("reset_busy", int'(hif.txhdr_busy), 0);
        check("reset_done", int'(hif.txhdr_done_p), 0);
        @(posedge clk_6M); #2;
        rstz = 1'b1;
        repeat (4) @(posedge clk_6M);

        // Fixed header, unwhitened reference case.
        start_hdr(3'b001, 4'h2, 1'b0, 1'b1, 1'b0, 8'h47, 6'h15, 0, 1'b1);
        wait_idle();

        // Start coinciding with bit_p.
        start_hdr(3'b101, 4'hA, 1'b1, 1'b0, 1'b1, 8'h9C, 6'h2A, 1, 1'b1);
        wait_idle();

        // Second start at air bit 20 must be ignored.
        done_before = got_done;
        start_rand(0);
        wait_bits(20);
        hif.start_p = 1'b1;
        scramble_fields();
        @(posedge clk_6M); #2;
        hif.start_p = 1'b0;
        wait_idle();
        check("one_done_with_ignored_start", got_done - done_before, 1);

        // Reset at air bit 30 abandons the header.
        start_rand(0);
        wait_bits(30);
        #20;
        rstz = 1'b0;
        #5;
        check("midreset_txbit", int'(hif.txbit), 0);
        check("midreset_busy", int'(hif.txhdr_busy), 0);
        exp_q.delete();
        exp_done--;
        done_before = got_done;
        repeat (3) @(posedge clk_6M);
        #2;
        rstz = 1'b1;
        repeat (400) @(posedge clk_6M);
        check("no_done_after_reset", got_done - done_before, 0);
        check("idle_after_reset", int'(hif.txhdr_busy), 0);

        // Zero whitening seed (model seed 7'h40 when whitening is built in).
        start_hdr(3'b011, 4'h4, 1'b1, 1'b1, 1'b0, 8'h00, 6'h00, 0, 1'b1);
        wait_idle();

        // Back-to-back headers: second start in the cycle after done_p.
        done_before = got_done;
        start_rand(0);
        begin
            int n;
            n = 0;
            while (!hif.txhdr_done_p && n < WAIT_MAX) begin
                @(posedge clk_6M); #2;
                n++;
            end
            check("done_seen_b2b", int'(hif.txhdr_done_p), 1);
        end
        start_rand(2);
        wait_idle();
        check("two_done_b2b", got_done - done_before, 2);

        // Randomized headers with random start phase.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 7)) @(posedge clk_6M);
            start_rand(int'($urandom_range(0, 1)));
            wait_idle();
        end

        repeat (10) @(posedge clk_6M);
        check("done_count", got_done, exp_done);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
